// File: rtl/game_pkg.sv
// Shared game geometry: platform table, character extents and motion state encoding.
// Used by the motion block and by the pixel-scan draw stage.
package game_pkg;

    localparam int NUM_PLATFORMS = 5;

    localparam logic [9:0] PLAT_X_START [NUM_PLATFORMS] = '{10'd60,  10'd220, 10'd100, 10'd180, 10'd140};
    localparam logic [9:0] PLAT_X_END   [NUM_PLATFORMS] = '{10'd100, 10'd260, 10'd140, 10'd220, 10'd180};
    localparam logic [9:0] PLAT_Y       [NUM_PLATFORMS] = '{10'd180, 10'd180, 10'd120, 10'd120, 10'd60};

    localparam logic [9:0] GRASS_ROW        = 10'd234;
    localparam logic [9:0] CHAR_ARM_LEFT    = 10'd3;
    localparam logic [9:0] CHAR_ARM_RIGHT   = 10'd10;
    localparam logic [9:0] CHAR_TORSO_RIGHT = 10'd7;
    localparam logic [9:0] CHAR_FEET_OFFSET = 10'd11;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2
    } motion_state_t;

    // True when the row just below the feet is a platform top that the torso overlaps.
    function automatic logic on_platform(input logic [9:0] x, input logic [9:0] y);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < NUM_PLATFORMS; p++) begin
            if ((y + CHAR_FEET_OFFSET + 10'd1) == PLAT_Y[p] &&
                (x + CHAR_TORSO_RIGHT) >= PLAT_X_START[p] &&
                x <= PLAT_X_END[p]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Motion tick generator: one-cycle pulse every DIV clocks, counter restarts from 0 on reset.
module tick_divider #(
    parameter int unsigned DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/character_motion.sv
// Robot position owner: walking, fixed-height jump, gravity and landing on ground/platforms.
// Position and state advance once per motion tick; frame_tick marks the first visible cycle.
module character_motion
    import game_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 1666666,
    parameter logic [9:0]  X_MIN       = 10'd3,
    parameter logic [9:0]  X_MAX       = 10'd309,
    parameter logic [9:0]  START_X     = 10'd3,
    parameter logic [9:0]  GROUND_Y    = 10'd222,
    parameter logic [9:0]  JUMP_HEIGHT = 10'd70
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_right,
    input  logic       key_left,
    input  logic       key_jump,
    output logic [9:0] char_x,
    output logic [9:0] char_y,
    output logic       airborne,
    output logic       frame_tick
);

    logic          tick;
    motion_state_t state_q, state_d;
    logic [9:0]    char_x_q, char_x_d;
    logic [9:0]    char_y_q, char_y_d;
    logic [9:0]    rise_cnt_q, rise_cnt_d;
    logic          jump_armed_q, jump_armed_d;
    logic          airborne_q, airborne_d;
    logic          frame_tick_q, frame_tick_d;
    logic          supported;
    logic          move_right, move_left;

    tick_divider #(
        .DIV (TICK_DIV)
    ) u_tick_divider (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Support is judged on the pre-tick position, so a step off an edge falls one tick later.
    assign supported  = ((char_y_q + 10'd12) == (GROUND_Y + 10'd12)) ||
                        on_platform(char_x_q, char_y_q);
    assign move_right = key_right & ~key_left;
    assign move_left  = key_left & ~key_right;

    always_comb begin
        state_d      = state_q;
        char_x_d     = char_x_q;
        char_y_d     = char_y_q;
        rise_cnt_d   = rise_cnt_q;
        airborne_d   = airborne_q;
        frame_tick_d = tick;
        jump_armed_d = key_jump ? jump_armed_q : 1'b1;

        if (tick) begin
            if (move_right && char_x_q < X_MAX) begin
                char_x_d = char_x_q + 10'd1;
            end else if (move_left && char_x_q > X_MIN) begin
                char_x_d = char_x_q - 10'd1;
            end

            case (state_q)
                GROUNDED: begin
                    if (key_jump && jump_armed_q) begin
                        state_d      = RISING;
                        rise_cnt_d   = '0;
                        jump_armed_d = 1'b0;
                    end else if (!supported) begin
                        state_d = FALLING;
                    end
                end
                RISING: begin
                    // Ceiling clamp: stop climbing rather than wrapping past row 0.
                    if (char_y_q == '0) begin
                        state_d = FALLING;
                    end else begin
                        char_y_d   = char_y_q - 10'd1;
                        rise_cnt_d = rise_cnt_q + 10'd1;
                        if (rise_cnt_q == JUMP_HEIGHT - 10'd1) begin
                            state_d = FALLING;
                        end
                    end
                end
                FALLING: begin
                    if (supported) begin
                        state_d = GROUNDED;
                    end else if (char_y_q < GROUND_Y) begin
                        char_y_d = char_y_q + 10'd1;
                    end
                end
                default: begin
                    state_d = GROUNDED;
                end
            endcase

            airborne_d = (state_d != GROUNDED);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= GROUNDED;
            char_x_q     <= START_X;
            char_y_q     <= GROUND_Y;
            rise_cnt_q   <= '0;
            jump_armed_q <= 1'b1;
            airborne_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            char_x_q     <= char_x_d;
            char_y_q     <= char_y_d;
            rise_cnt_q   <= rise_cnt_d;
            jump_armed_q <= jump_armed_d;
            airborne_q   <= airborne_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign char_x     = char_x_q;
    assign char_y     = char_y_q;
    assign airborne   = airborne_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_character_motion.sv
// Self-checking bench for character_motion: directed scenarios plus random keys,
// compared every cycle against a behavioural model of the motion rules.
module tb_character_motion;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_right = 1'b0;
    logic       key_left = 1'b0;
    logic       key_jump = 1'b0;
    logic [9:0] char_x;
    logic [9:0] char_y;
    logic       airborne;
    logic       frame_tick;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    character_motion #(
        .TICK_DIV (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .key_right  (key_right),
        .key_left   (key_left),
        .key_jump   (key_jump),
        .char_x     (char_x),
        .char_y     (char_y),
        .airborne   (airborne),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    localparam int M_GROUND = 0;
    localparam int M_UP     = 1;
    localparam int M_DOWN   = 2;

    int px0 [5] = '{60, 220, 100, 180, 140};
    int px1 [5] = '{100, 260, 140, 220, 180};
    int py  [5] = '{180, 180, 120, 120, 60};

    int m_x = 3;
    int m_y = 222;
    int m_mode = M_GROUND;
    int m_rows = 0;
    int m_phase = 0;
    bit m_armed = 1'b1;
    bit m_ftick = 1'b0;
    bit m_air = 1'b0;

    int nx, ny, nmode;
    bit t;

    function automatic bit standing(int x, int y);
        if (y == 222) return 1'b1;
        for (int p = 0; p < 5; p++)
            if (y + 12 == py[p] && x + 7 >= px0[p] && x <= px1[p]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_x = 3; m_y = 222; m_mode = M_GROUND; m_rows = 0;
            m_phase = 0; m_armed = 1'b1; m_ftick = 1'b0; m_air = 1'b0;
        end else begin
            t = (m_phase == 3);
            m_phase = (m_phase + 1) % 4;
            m_ftick = t;
            if (!key_jump) m_armed = 1'b1;
            if (t) begin
                nx = m_x;
                if (key_right && !key_left) nx = (m_x + 1 > 309) ? 309 : m_x + 1;
                if (key_left && !key_right) nx = (m_x - 1 < 3) ? 3 : m_x - 1;
                ny = m_y;
                nmode = m_mode;
                if (m_mode == M_GROUND) begin
                    if (key_jump && m_armed) begin
                        nmode = M_UP; m_rows = 0; m_armed = 1'b0;
                    end else if (!standing(m_x, m_y)) begin
                        nmode = M_DOWN;
                    end
                end else if (m_mode == M_UP) begin
                    if (m_y == 0) nmode = M_DOWN;
                    else begin
                        ny = m_y - 1;
                        m_rows = m_rows + 1;
                        if (m_rows == 70) nmode = M_DOWN;
                    end
                end else begin
                    if (standing(m_x, m_y)) nmode = M_GROUND;
                    else if (m_y < 222) ny = m_y + 1;
                end
                m_x = nx; m_y = ny; m_mode = nmode;
                m_air = (m_mode != M_GROUND);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (check_en) begin
            checks++;
            if (int'(char_x) != m_x || int'(char_y) != m_y ||
                airborne != m_air || frame_tick != m_ftick) begin
                failures++;
                $display("FAIL cycle_compare t=%0t: got x=%0d y=%0d air=%0b ft=%0b expected x=%0d y=%0d air=%0b ft=%0b",
                         $time, char_x, char_y, airborne, frame_tick, m_x, m_y, m_air, m_ftick);
            end
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(negedge clock); while (!m_ftick);
        end
        #1;
    endtask

    task automatic jump_pulse();
        @(negedge clock);
        key_jump = 1'b1;
        wait_ticks(1);
        @(negedge clock);
        key_jump = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        repeat (3) @(negedge clock);
        check_en = 1'b1;
        #1;
        check_lit("reset_x", char_x, 3);
        check_lit("reset_y", char_y, 222);
        check_lit("reset_air", airborne, 0);
        check_lit("reset_ftick", frame_tick, 0);
        @(negedge clock);
        reset = 1'b0;

        // Walk right 10 ticks
        key_right = 1'b1;
        wait_ticks(10);
        check_lit("walk10_x", char_x, 13);
        check_lit("walk10_y", char_y, 222);

        // Right saturation
        while (m_x < 305) wait_ticks(1);
        wait_ticks(8);
        check_lit("sat_right_x", char_x, 309);

        // Left saturation
        @(negedge clock);
        key_right = 1'b0; key_left = 1'b1;
        while (m_x > 3) wait_ticks(1);
        wait_ticks(3);
        check_lit("sat_left_x", char_x, 3);

        @(negedge clock);
        key_left = 1'b0; key_right = 1'b1;
        wait_ticks(10);
        @(negedge clock);
        key_left = 1'b1;
        wait_ticks(5);
        check_lit("both_keys_x", char_x, 13);

        // Ground jump at x=20
        @(negedge clock);
        key_left = 1'b0;
        wait_ticks(7);
        @(negedge clock);
        key_right = 1'b0;
        check_lit("pre_jump_x", char_x, 20);
        jump_pulse();
        wait_ticks(70);
        check_lit("apex_y", char_y, 152);
        check_lit("apex_air", airborne, 1);
        wait_ticks(71);
        check_lit("land_y", char_y, 222);
        check_lit("land_air", airborne, 0);

        // Jump through platform 1 and land on it
        @(negedge clock);
        key_right = 1'b1;
        wait_ticks(50);
        @(negedge clock);
        key_right = 1'b0;
        jump_pulse();
        wait_ticks(87);
        check_lit("plat_land_y", char_y, 168);
        check_lit("plat_land_air", airborne, 0);
        @(negedge clock);
        key_right = 1'b1;
        wait_ticks(31);
        @(negedge clock);
        key_right = 1'b0;
        check_lit("edge_x", char_x, 101);
        check_lit("edge_air_before", airborne, 0);
        wait_ticks(1);
        check_lit("edge_air_after", airborne, 1);
        check_lit("edge_y_after", char_y, 168);
        wait_ticks(60);
        check_lit("edge_fall_y", char_y, 222);

        // Held jump: exactly one jump
        @(negedge clock);
        key_jump = 1'b1;
        wait_ticks(200);
        check_lit("held_jump_y", char_y, 222);
        check_lit("held_jump_air", airborne, 0);
        @(negedge clock);
        key_jump = 1'b0;
        wait_ticks(1);
        @(negedge clock);
        key_jump = 1'b1;
        wait_ticks(10);
        check_lit("rejump_y", char_y, 213);
        wait_ticks(23);
        check_lit("mid_rise_y", char_y, 190);

        // Asynchronous reset mid-rise
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_lit("areset_x", char_x, 3);
        check_lit("areset_y", char_y, 222);
        check_lit("areset_air", airborne, 0);
        key_jump = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (frame_tick && lat == 0) lat = i;
        end
        check_lit("tick_restart_latency", lat, 4);

        // Climb to the top platform and hit the ceiling
        @(negedge clock);
        key_right = 1'b1;
        while (m_x < 100) wait_ticks(1);
        @(negedge clock);
        key_right = 1'b0;
        jump_pulse();
        wait_ticks(87);
        check_lit("climb1_y", char_y, 168);
        jump_pulse();
        wait_ticks(81);
        check_lit("climb2_y", char_y, 108);
        @(negedge clock);
        key_right = 1'b1;
        while (m_x < 140) wait_ticks(1);
        @(negedge clock);
        key_right = 1'b0;
        jump_pulse();
        wait_ticks(81);
        check_lit("climb3_y", char_y, 48);
        jump_pulse();
        wait_ticks(48);
        check_lit("ceiling_y", char_y, 0);
        check_lit("ceiling_air", airborne, 1);
        wait_ticks(50);
        check_lit("ceiling_land_y", char_y, 48);
        check_lit("ceiling_land_air", airborne, 0);

        // Random keys
        for (int seg = 0; seg < 120; seg++) begin
            int r;
            @(negedge clock);
            r = $urandom_range(0, 9);
            key_right = (r inside {0, 1, 2, 6});
            key_left  = (r inside {3, 4, 6, 7});
            key_jump  = (r inside {2, 5, 7, 8}) || ($urandom_range(0, 3) == 0);
            wait_ticks($urandom_range(1, 12));
        end
        @(negedge clock);
        key_right = 1'b0; key_left = 1'b0; key_jump = 1'b0;
        wait_ticks(5);

        check_en = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
